// File: rtl/imem_arbiter.sv
// Shares the asynchronous instruction-ROM read port between CPU fetch (priority) and a secondary reader.
// Fetch and dbg grant are combinational; the dbg response is registered one cycle after the grant.
module imem_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [DATA_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_stall,
    input  logic                  dbg_req,
    input  logic [DATA_WIDTH-1:0] dbg_addr,
    output logic                  dbg_gnt,
    output logic                  dbg_valid,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_err,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    typedef enum logic {
        FETCH_PRIO = 1'b0,
        DBG_SLOT   = 1'b1
    } state_t;

    localparam logic [3:0]            WAIT_LAST = 4'(MAX_WAIT - 1);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  dbg_valid_q;
    logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
    logic                  dbg_err_q, dbg_err_d;

    logic fetch_win;
    logic dbg_win;
    logic dbg_bad_addr;

    assign dbg_bad_addr = (dbg_addr[1:0] != 2'b00) ||
                          (dbg_addr[DATA_WIDTH-1:ADDRESS_WIDTH] != '0);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fetch_win  = 1'b0;
        dbg_win    = 1'b0;

        case (state_q)
            FETCH_PRIO: begin
                fetch_win = fetch_req;
                dbg_win   = dbg_req & ~fetch_req;
            end
            DBG_SLOT: begin
                dbg_win   = dbg_req;
                fetch_win = fetch_req & ~dbg_req;
            end
            default: begin
                fetch_win = fetch_req;
            end
        endcase

        // Counter saturates so the forced slot is armed until dbg is finally served.
        if (dbg_req && !dbg_win) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = 4'd0;
        end

        case (state_q)
            FETCH_PRIO: begin
                if (dbg_req && !dbg_win && (wait_cnt_q == WAIT_LAST)) begin
                    state_d = DBG_SLOT;
                end
            end
            default: state_d = FETCH_PRIO;
        endcase

        dbg_data_d = dbg_data_q;
        dbg_err_d  = dbg_err_q;
        if (dbg_win) begin
            dbg_err_d  = dbg_bad_addr;
            dbg_data_d = dbg_bad_addr ? '0 : rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH_PRIO;
            wait_cnt_q  <= 4'd0;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_valid_q <= dbg_win;
            dbg_data_q  <= dbg_data_d;
            dbg_err_q   <= dbg_err_d;
        end
    end

    // While reset is held the ROM port is parked and fetch sees a stalled NOP.
    always_comb begin
        if (!rst) begin
            dbg_gnt     = 1'b0;
            fetch_stall = 1'b1;
            rom_addr    = '0;
            fetch_instr = NOP_INSTR;
        end else begin
            dbg_gnt     = dbg_win;
            fetch_stall = fetch_req & ~fetch_win;
            rom_addr    = fetch_win ? fetch_addr : (dbg_win ? dbg_addr : '0);
            fetch_instr = fetch_win ? rom_data : NOP_INSTR;
        end
    end

    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;
    assign dbg_err   = dbg_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table for single-cycle behaviour,
// hand-written sequences for starvation and reset-during-request.
module tb_imem_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        fetch_stall;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    logic [31:0] rom [64];

    int n_cmp;
    int n_bad;

    imem_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .fetch_stall(fetch_stall),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data),
        .dbg_err    (dbg_err),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    // ROM truncates the byte address to a word index.
    assign rom_data = rom[rom_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] e_instr;
        logic        e_stall;
        logic        e_gnt;
        logic [31:0] e_rom_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = fa;
        dbg_req    = dr;
        dbg_addr   = da;
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h0010_8113;
        rom[2] = 32'h0000_0013;

        //          freq fetch_addr dreq dbg_addr     instr         stall gnt rom_addr      valid data           err
        vecs[0]  = '{1'b0, 32'h0,  1'b0, 32'h0,   NOP,          1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0,  1'b0, 32'h0,   32'h00500093, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 32'h4,  1'b0, 32'h0,   32'h00108113, 1'b0, 1'b0, 32'h4,   1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h8,  1'b0, 32'h0,   32'h00000013, 1'b0, 1'b0, 32'h8,   1'b0, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0,  1'b1, 32'h4,   NOP,          1'b0, 1'b1, 32'h4,   1'b0, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 32'h0,   NOP,          1'b0, 1'b0, 32'h0,   1'b1, 32'h00108113,  1'b0};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 32'h6,   NOP,          1'b0, 1'b1, 32'h6,   1'b0, 32'h00108113,  1'b0};
        vecs[7]  = '{1'b0, 32'h0,  1'b1, 32'h100, NOP,          1'b0, 1'b1, 32'h100, 1'b1, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 32'h0,   NOP,          1'b0, 1'b0, 32'h0,   1'b1, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 32'h8,   NOP,          1'b0, 1'b1, 32'h8,   1'b0, 32'h0,         1'b1};
        vecs[10] = '{1'b1, 32'hC,  1'b0, 32'h0,   32'hA0000003, 1'b0, 1'b0, 32'hC,   1'b1, 32'h00000013,  1'b0};

        rst = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #2;
            check("rst_stall", {31'b0, fetch_stall}, 32'd1);
            check("rst_instr", fetch_instr, NOP);
            check("rst_valid", {31'b0, dbg_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_addr);
            check($sformatf("v%0d_instr", i), fetch_instr, vecs[i].e_instr);
            check($sformatf("v%0d_stall", i), {31'b0, fetch_stall}, {31'b0, vecs[i].e_stall});
            check($sformatf("v%0d_gnt", i),   {31'b0, dbg_gnt}, {31'b0, vecs[i].e_gnt});
            check($sformatf("v%0d_romaddr", i), rom_addr, vecs[i].e_rom_addr);
            check($sformatf("v%0d_valid", i), {31'b0, dbg_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_data", i),  dbg_data, vecs[i].e_data);
            check($sformatf("v%0d_err", i),   {31'b0, dbg_err}, {31'b0, vecs[i].e_err});
        end

        // Starvation: fetch hogs the port, dbg is forced in on the 5th cycle.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'h10, (c <= 4), 32'hC);
            check($sformatf("st%0d_gnt", c),   {31'b0, dbg_gnt},     {31'b0, (c == 4)});
            check($sformatf("st%0d_stall", c), {31'b0, fetch_stall}, {31'b0, (c == 4)});
            check($sformatf("st%0d_romaddr", c), rom_addr, (c == 4) ? 32'hC : 32'h10);
            check($sformatf("st%0d_instr", c), fetch_instr, (c == 4) ? NOP : 32'hA0000004);
            check($sformatf("st%0d_valid", c), {31'b0, dbg_valid},   {31'b0, (c == 5)});
        end
        check("st_data", dbg_data, 32'hA0000003);
        check("st_err", {31'b0, dbg_err}, 32'd0);

        // Reset while dbg is pending: two denied cycles, then reset pulse.
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h0, 1'b1, 32'h8);
            check($sformatf("pr%0d_gnt", c), {31'b0, dbg_gnt}, 32'd0);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mr_gnt",     {31'b0, dbg_gnt},     32'd0);
        check("mr_stall",   {31'b0, fetch_stall}, 32'd1);
        check("mr_romaddr", rom_addr,             32'h0);
        check("mr_instr",   fetch_instr,          NOP);
        check("mr_data",    dbg_data,             32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #2;
            check($sformatf("mr%0d_valid", c), {31'b0, dbg_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) drive(1'b1, 32'h0, (c <= 4), 32'h8);
            check($sformatf("ar%0d_gnt", c),   {31'b0, dbg_gnt},   {31'b0, (c == 4)});
            check($sformatf("ar%0d_valid", c), {31'b0, dbg_valid}, {31'b0, (c == 5)});
        end
        check("ar_data", dbg_data, 32'h00000013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single asynchronous read port of the instruction ROM between two requesters. The CPU fetch path is requester 0. A secondary read port (debug/constant-table reader) is requester 1. Fetch has priority, and a starvation counter guarantees the secondary port a slot. The block sits between the fetch stage, the debug reader and the ROM address/data pins, and drives the fetch-stage stall.

Parameters:
ADDRESS_WIDTH, 8, byte-address width of the ROM (ROM holds 2**(ADDRESS_WIDTH-2) words)
DATA_WIDTH, 32, address and data width of all ports
MAX_WAIT, 4, consecutive denied cycles after which the secondary port is forced a grant (legal range 1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
fetch_req  input  1  fetch stage wants an instruction this cycle
fetch_addr  input  DATA_WIDTH  fetch byte address (PC)
fetch_instr  output  DATA_WIDTH  instruction for fetch, combinational from rom_data
fetch_stall  output  1  fetch did not get the ROM this cycle; PC must hold
dbg_req  input  1  secondary read request; held with stable dbg_addr until granted
dbg_addr  input  DATA_WIDTH  secondary byte address
dbg_gnt  output  1  secondary request accepted this cycle (combinational)
dbg_valid  output  1  registered response strobe, one cycle after dbg_gnt
dbg_data  output  DATA_WIDTH  registered response word
dbg_err  output  1  registered with dbg_valid: address misaligned or out of range
rom_addr  output  DATA_WIDTH  address driven to the ROM PC input
rom_data  input  DATA_WIDTH  ROM instr output (asynchronous)

Behaviour:
- Reset (rst low, asynchronous): dbg_valid=0, dbg_data=0, dbg_err=0, wait_cnt=0, state=FETCH_PRIO. While rst is low, combinational outputs are forced: dbg_gnt=0, fetch_stall=1, rom_addr=0, fetch_instr=0x00000013 (NOP).
- State machine, two states:
  - FETCH_PRIO: winner is fetch if fetch_req=1, else dbg if dbg_req=1.
  - DBG_SLOT: winner is dbg if dbg_req=1, else fetch.
- Transitions:
  - FETCH_PRIO -> DBG_SLOT when dbg_req=1, dbg is denied and wait_cnt==MAX_WAIT-1.
  - DBG_SLOT -> FETCH_PRIO unconditionally after one cycle.
- wait_cnt:
  - Increments in any cycle where dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt=1, or when dbg_req=0.
  - Saturates at MAX_WAIT-1.
- Worst-case dbg grant latency: MAX_WAIT cycles after dbg_req rises.
- rom_addr = address of the winner; 0 when there is no request.
- fetch_instr = rom_data when fetch wins, else 0x00000013.
- fetch_stall = fetch_req & ~(fetch wins). Zero-latency fetch when granted.
- dbg_gnt = dbg_req & (dbg wins).
- On dbg_gnt, at the next edge:
  - dbg_valid<=1.
  - dbg_data<=rom_data, or 0 on error.
  - dbg_err<=1 if dbg_addr[1:0]!=0 or dbg_addr[DATA_WIDTH-1:ADDRESS_WIDTH]!=0.
  - dbg_valid is a single-cycle pulse; dbg_data/dbg_err hold until the next grant.
- Fetch address range is not checked; the ROM truncation applies.
- Back-to-back dbg grants are legal (new request the cycle after a grant), e.g. when fetch_req=0.
- Simultaneous requests in DBG_SLOT: dbg wins, fetch_stall=1 for exactly that one cycle.
- Reset mid-request: a pending dbg request is dropped, and the requester re-arbitrates after reset with wait_cnt=0.

Test Plan:
- rst low 3 cycles, then high with both requests idle -> dbg_valid=0, dbg_gnt=0, fetch_stall=0, rom_addr=0; during reset fetch_stall=1 and fetch_instr=0x00000013.
- fetch_req=1 only, fetch_addr=0x0, 0x4, 0x8 on successive cycles (ROM preloaded 0x00500093, 0x00108113, 0x00000013) -> fetch_instr matches in the same cycle, fetch_stall=0 throughout.
- dbg_req=1, dbg_addr=0x4, fetch_req=0 -> dbg_gnt=1 in cycle 0; dbg_valid=1, dbg_data=0x00108113, dbg_err=0 in cycle 1.
- fetch_req held 1 and dbg_req=1 (MAX_WAIT=4) from cycle 0 -> dbg_gnt=0 in cycles 0-3 and =1 in cycle 4, with fetch_stall=1 only in cycle 4; dbg_valid in cycle 5; fetch resumes in cycle 5.
- dbg_addr=0x6 -> dbg_err=1, dbg_data=0; dbg_addr=0x100 (ADDRESS_WIDTH=8) -> dbg_err=1, dbg_data=0.
- dbg_req held denied for 2 cycles, rst pulsed low, dbg_req kept high -> after reset the grant comes MAX_WAIT cycles after reset release (wait_cnt restarted); no spurious dbg_valid during or just after reset.
